axis_packet_rr_arbiter: RTL and testbench
=========================================

AXIS_PACKET_RR_ARBITER -- requirements
Module: axis_packet_rr_arbiter

Interface
REQ-001 SHALL have parameter IF_COUNT_IN, default 3, giving the number of AXI-Stream input ports (2..8).
REQ-002 SHALL have parameter AXIS_DATA_WIDTH, default 64, giving the data width per port.
REQ-003 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, giving the keep width per port.
REQ-004 SHALL have parameter AXIS_ID_WIDTH, default $clog2(IF_COUNT_IN), giving the output source-index width.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports s_axis_arb_tdata/tkeep/tvalid/tlast, input, IF_COUNT_IN x (DATA/KEEP/1/1): packed input streams, port i in slice i.
REQ-008 SHALL have port s_axis_arb_tready, output, IF_COUNT_IN: per-input ready.
REQ-009 SHALL have ports m_axis_arb_tdata/tkeep/tvalid/tlast, output, DATA/KEEP/1/1: merged output stream.
REQ-010 SHALL have port m_axis_arb_tready, input, 1 bit: output ready.
REQ-011 SHALL have port m_axis_arb_tid, output, AXIS_ID_WIDTH: index of the granted input.
REQ-012 SHALL have port w_enable_arb, input, 1 bit: when low, no new grant is issued.
REQ-013 SHALL have port w_rst_pkt_counter, input, 1 bit: synchronous clear of the packet counters.
REQ-014 SHALL have port w_pkt_counter, output, IF_COUNT_IN x 32: per-input completed-packet counts.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-016 In IDLE with w_enable_arb=1 and any s tvalid=1, SHALL register the grant as the first valid input searching from (last_grant+1) mod IF_COUNT_IN upward with wrap-around, then enter BUSY next cycle; arbitration latency is 1 cycle.
REQ-017 In IDLE, SHALL drive m tvalid=0 and all s tready=0.
REQ-018 In BUSY, SHALL forward granted input tdata/tkeep/tvalid/tlast combinationally to m, drive m_axis_arb_tid=grant, and drive granted s tready=m_axis_arb_tready; all other s tready SHALL be 0.
REQ-019 Grant SHALL be packet-granular: the grant is held from first beat until the beat with tvalid&tready&tlast on the granted input.
REQ-020 On that final beat, SHALL set last_grant<=grant and return to IDLE; one idle cycle separates back-to-back packets.
REQ-021 Deasserting w_enable_arb in BUSY SHALL NOT abort the packet; it blocks only the next grant.
REQ-022 A single-beat packet (tlast on first beat) SHALL complete in one BUSY cycle when m tready=1.
REQ-023 Backpressure (m tready=0) SHALL hold all outputs stable while in BUSY; no beat is lost or duplicated.
REQ-024 In IDLE, m_axis_arb_tid SHALL hold the last grant value.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, grant=0, last_grant=IF_COUNT_IN-1 (input 0 has first priority), counters=0, m tvalid=0, all s tready=0, m tid=0.
REQ-026 Reset mid-packet SHALL abandon the packet; after release, arbitration restarts from input 0 with no partial-packet recovery.

Configuration
REQ-027 With macro ARB_PKT_COUNTER_EN defined, SHALL increment w_pkt_counter[i] by 1 (32-bit, wraps 0xFFFFFFFF->0) on each completed packet of input i.
REQ-028 With ARB_PKT_COUNTER_EN defined, w_rst_pkt_counter=1 SHALL clear all counters next cycle; clear wins over a simultaneous increment.
REQ-029 Without ARB_PKT_COUNTER_EN, w_pkt_counter SHALL be tied to 0, w_rst_pkt_counter SHALL be ignored, and no counter registers are generated.

Verification
REQ-030 Inputs 0,1,2 each hold a 3-beat packet from cycle 0 -> output order 0,1,2; m tid=0,1,2; one idle cycle between packets.
REQ-031 Input 1 streams continuously while input 2 has one packet -> packets alternate 1,2,1; input 2 never starved.
REQ-032 m tready toggled 1,0 during a 4-beat packet on input 0 -> 4 beats out, unchanged data, tlast on beat 4 only.
REQ-033 w_enable_arb dropped on beat 2 of a 3-beat packet -> packet completes; no new grant until re-enabled.
REQ-034 rst_n pulsed low on beat 2 -> m tvalid=0 immediately; after release, input 0 granted first.
REQ-035 With ARB_PKT_COUNTER_EN: 5 packets on input 2, then clear coincident with a 6th completion -> w_pkt_counter[2]=5, then 0.

Source files
------------

// File: rtl/axis_packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_rr_arbiter
// Purpose  : Packet-granular round-robin arbiter merging IF_COUNT_IN
//            AXI-Stream inputs onto one output stream. Once an input wins
//            arbitration it keeps the output until its tlast beat is
//            accepted. One idle cycle separates consecutive packets.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            s_axis_arb_t*         - packed input streams (port i in slice i)
//            s_axis_arb_tready     - per-input ready
//            m_axis_arb_t*         - merged output stream
//            m_axis_arb_tid        - index of the granted input
//            w_enable_arb          - low blocks new grants (never aborts)
//            w_rst_pkt_counter     - synchronous clear of packet counters
//            w_pkt_counter         - per-input completed-packet counts
// Options  : ARB_PKT_COUNTER_EN    - when defined, builds the 32-bit
//                                    per-input packet counters; otherwise
//                                    w_pkt_counter is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_rr_arbiter #(
  parameter int IF_COUNT_IN     = 3,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_ID_WIDTH   = $clog2(IF_COUNT_IN)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [IF_COUNT_IN*AXIS_DATA_WIDTH-1:0] s_axis_arb_tdata,
  input  logic [IF_COUNT_IN*AXIS_KEEP_WIDTH-1:0] s_axis_arb_tkeep,
  input  logic [IF_COUNT_IN-1:0]                 s_axis_arb_tvalid,
  input  logic [IF_COUNT_IN-1:0]                 s_axis_arb_tlast,
  output logic [IF_COUNT_IN-1:0]                 s_axis_arb_tready,
  output logic [AXIS_DATA_WIDTH-1:0]             m_axis_arb_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]             m_axis_arb_tkeep,
  output logic                                   m_axis_arb_tvalid,
  output logic                                   m_axis_arb_tlast,
  input  logic                                   m_axis_arb_tready,
  output logic [AXIS_ID_WIDTH-1:0]               m_axis_arb_tid,
  input  logic                                   w_enable_arb,
  input  logic                                   w_rst_pkt_counter,
  output logic [IF_COUNT_IN*32-1:0]              w_pkt_counter
);

  localparam int IDX_W = (IF_COUNT_IN > 1) ? $clog2(IF_COUNT_IN) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant_q;

  logic [IDX_W-1:0] next_grant_d;
  logic             req_found_d;

  logic [AXIS_DATA_WIDTH-1:0] sel_data;
  logic [AXIS_KEEP_WIDTH-1:0] sel_keep;
  logic                       sel_valid;
  logic                       sel_last;
  logic                       busy;
  logic                       final_beat;

  // Round-robin search: first valid input starting just after the last
  // completed grant, wrapping modulo IF_COUNT_IN (which need not be 2^n).
  always_comb begin
    int cand;
    cand         = 0;
    req_found_d  = 1'b0;
    next_grant_d = '0;
    for (int off = 1; off <= IF_COUNT_IN; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= IF_COUNT_IN) begin
        cand = cand - IF_COUNT_IN;
      end
      if (!req_found_d && s_axis_arb_tvalid[IDX_W'(cand)]) begin
        req_found_d  = 1'b1;
        next_grant_d = IDX_W'(cand);
      end
    end
  end

  // Select the granted input's beat.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < IF_COUNT_IN; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_data  = s_axis_arb_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        sel_keep  = s_axis_arb_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
        sel_valid = s_axis_arb_tvalid[i];
        sel_last  = s_axis_arb_tlast[i];
      end
    end
  end

  assign busy       = (state_q == ST_BUSY);
  assign final_beat = busy && sel_valid && sel_last && m_axis_arb_tready;

  // Output path is combinational from the granted input so a beat can
  // pass every cycle; gating with busy makes reset take effect at once.
  assign m_axis_arb_tdata  = sel_data;
  assign m_axis_arb_tkeep  = sel_keep;
  assign m_axis_arb_tvalid = busy && sel_valid;
  assign m_axis_arb_tlast  = busy && sel_last;
  assign m_axis_arb_tid    = AXIS_ID_WIDTH'(grant_q);

  always_comb begin
    s_axis_arb_tready = '0;
    for (int i = 0; i < IF_COUNT_IN; i++) begin
      s_axis_arb_tready[i] = busy && (grant_q == IDX_W'(i)) && m_axis_arb_tready;
    end
  end

  // Arbitration FSM. last_grant resets to the highest index so input 0
  // is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(IF_COUNT_IN - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_enable_arb && req_found_d) begin
            grant_q <= next_grant_d;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // w_enable_arb is deliberately ignored here: a packet in flight
          // always runs to its tlast beat.
          if (final_beat) begin
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PKT_COUNTER_EN
  logic [31:0] pkt_cnt_q [IF_COUNT_IN];

  // Clear has priority over a coincident packet completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IF_COUNT_IN; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else if (w_rst_pkt_counter) begin
      for (int i = 0; i < IF_COUNT_IN; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else if (final_beat) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar g = 0; g < IF_COUNT_IN; g++) begin : g_cnt_out
    assign w_pkt_counter[g*32 +: 32] = pkt_cnt_q[g];
  end
`else
  logic unused_rst_pkt_counter;
  assign unused_rst_pkt_counter = w_rst_pkt_counter;
  assign w_pkt_counter          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_rr_arbiter
// Purpose  : Directed self-checking bench for axis_packet_rr_arbiter with
//            IF_COUNT_IN=3, 64-bit data. Packet sources advance on observed
//            handshakes; accepted output beats are logged and compared
//            against hand-computed order, timing and contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*DW-1:0] s_tdata  = '0;
  logic [N*KW-1:0] s_tkeep  = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tlast  = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready = 1'b1;
  logic [IW-1:0]   m_tid;
  logic            en_arb = 1'b1;
  logic            rst_cnt = 1'b0;
  logic [N*32-1:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_packet_rr_arbiter #(
    .IF_COUNT_IN    (N),
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_ID_WIDTH  (IW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_arb_tdata (s_tdata),
    .s_axis_arb_tkeep (s_tkeep),
    .s_axis_arb_tvalid(s_tvalid),
    .s_axis_arb_tlast (s_tlast),
    .s_axis_arb_tready(s_tready),
    .m_axis_arb_tdata (m_tdata),
    .m_axis_arb_tkeep (m_tkeep),
    .m_axis_arb_tvalid(m_tvalid),
    .m_axis_arb_tlast (m_tlast),
    .m_axis_arb_tready(m_tready),
    .m_axis_arb_tid   (m_tid),
    .w_enable_arb     (en_arb),
    .w_rst_pkt_counter(rst_cnt),
    .w_pkt_counter    (pkt_cnt)
  );

  int ncmp = 0;
  int nerr = 0;

  // Source state per input
  int src_pkts [N];
  int src_len  [N];
  int src_beat [N];
  int src_pkt  [N];
  // Per-cycle controls, applied at the driving edge
  logic nxt_ready;
  logic nxt_en;
  logic nxt_rstcnt;
  int   cyc;

  // Log of accepted output beats
  int          lg_tid  [$];
  int          lg_cyc  [$];
  logic [63:0] lg_data [$];
  logic [7:0]  lg_keep [$];
  logic        lg_last [$];

  function automatic logic [63:0] data_of(int p, int k, int b);
    return {8'hA5, 8'(p), 8'(k), 8'(b), 32'hC0DE0000 ^ 32'(p*256 + k*16 + b)};
  endfunction

  function automatic logic [7:0] keep_of(int b);
    logic [7:0] full;
    full = 8'hFF;
    return full >> (b % 4);
  endfunction

  task automatic clear_log();
    lg_tid.delete(); lg_cyc.delete(); lg_data.delete();
    lg_keep.delete(); lg_last.delete();
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_pkts[i] = 0; src_len[i] = 1; src_beat[i] = 0; src_pkt[i] = 0;
    end
  endtask

  task automatic drive_inputs();
    m_tready = nxt_ready;
    en_arb   = nxt_en;
    rst_cnt  = nxt_rstcnt;
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]         = (src_pkts[i] > 0);
      s_tdata[i*DW +: DW] = data_of(i, src_pkt[i], src_beat[i]);
      s_tkeep[i*KW +: KW] = keep_of(src_beat[i]);
      s_tlast[i]          = (src_beat[i] == src_len[i] - 1);
    end
  endtask

  // Drive at the falling edge, then observe what the next rising edge
  // will sample. Returns with this cycle's values still on the ports.
  task automatic run_cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    if (m_tvalid && m_tready) begin
      lg_tid.push_back(int'(m_tid));
      lg_cyc.push_back(cyc);
      lg_data.push_back(m_tdata);
      lg_keep.push_back(m_tkeep);
      lg_last.push_back(m_tlast);
    end
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0; src_pkt[i]++; src_pkts[i]--;
        end else begin
          src_beat[i]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    nxt_ready = 1'b1; nxt_en = 1'b1; nxt_rstcnt = 1'b0;
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b1; en_arb = 1'b1; rst_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    clear_log();
  endtask

  task automatic test_reset();
    clear_src();
    #3 rst_n = 1'b0;
    #1;
    ncmp++;
    if (m_tvalid !== 1'b0 || s_tready !== 3'b000 || m_tid !== 2'd0 || pkt_cnt !== '0) begin
      nerr++;
      $display("FAIL reset_state: tvalid=%b tready=%b tid=%0d cnt=%0h, want 0/000/0/0",
               m_tvalid, s_tready, m_tid, pkt_cnt);
    end
    do_reset();
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int i = 0; i < N; i++) begin src_pkts[i] = 1; src_len[i] = 3; end
    for (int c = 0; c < 15; c++) begin
      run_cycle();
      if (c == 0 || c == 4 || c == 8) begin
        ncmp++;
        if (m_tvalid !== 1'b0) begin
          nerr++; $display("FAIL rr_idle_gap c%0d: tvalid=%b want 0", c, m_tvalid);
        end
      end
      if (c == 4 || c == 8) begin
        ncmp++;
        if (int'(m_tid) !== c / 4 - 1) begin
          nerr++; $display("FAIL rr_idle_tid c%0d: tid=%0d want %0d", c, m_tid, c / 4 - 1);
        end
      end
    end
    ncmp++;
    if (lg_tid.size() !== 9) begin
      nerr++; $display("FAIL rr_beat_count: got %0d want 9", lg_tid.size());
    end
    for (int k = 0; k < lg_tid.size() && k < 9; k++) begin
      int p, b, ec;
      p = k / 3; b = k % 3; ec = k + k / 3 + 1;
      ncmp++;
      if (lg_tid[k] !== p || lg_cyc[k] !== ec || lg_data[k] !== data_of(p, 0, b) ||
          lg_keep[k] !== keep_of(b) || lg_last[k] !== (b == 2)) begin
        nerr++;
        $display("FAIL rr_beat%0d: tid=%0d cyc=%0d data=%h last=%b, want tid=%0d cyc=%0d data=%h last=%b",
                 k, lg_tid[k], lg_cyc[k], lg_data[k], lg_last[k], p, ec, data_of(p, 0, b), b == 2);
      end
    end
  endtask

  task automatic test_fairness();
    int ep [8] = '{1, 1, 2, 2, 1, 1, 1, 1};
    int ek [8] = '{0, 0, 0, 0, 1, 1, 2, 2};
    int ec [8] = '{1, 2, 4, 5, 7, 8, 10, 11};
    do_reset();
    src_pkts[1] = 3; src_len[1] = 2;
    src_pkts[2] = 1; src_len[2] = 2;
    for (int c = 0; c < 14; c++) run_cycle();
    ncmp++;
    if (lg_tid.size() !== 8) begin
      nerr++; $display("FAIL fair_beat_count: got %0d want 8", lg_tid.size());
    end
    for (int k = 0; k < lg_tid.size() && k < 8; k++) begin
      ncmp++;
      if (lg_tid[k] !== ep[k] || lg_cyc[k] !== ec[k] ||
          lg_data[k] !== data_of(ep[k], ek[k], k % 2) || lg_last[k] !== (k % 2 == 1)) begin
        nerr++;
        $display("FAIL fair_beat%0d: tid=%0d cyc=%0d data=%h, want tid=%0d cyc=%0d data=%h",
                 k, lg_tid[k], lg_cyc[k], lg_data[k], ep[k], ec[k], data_of(ep[k], ek[k], k % 2));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_pkts[0] = 1; src_len[0] = 4;
    for (int c = 0; c < 10; c++) begin
      nxt_ready = (c % 2 == 1);
      run_cycle();
      if (c == 2 || c == 4 || c == 6) begin
        ncmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== data_of(0, 0, c / 2) || s_tready[0] !== 1'b0) begin
          nerr++;
          $display("FAIL bp_stall_hold c%0d: tvalid=%b data=%h rdy=%b, want 1/%h/0",
                   c, m_tvalid, m_tdata, s_tready[0], data_of(0, 0, c / 2));
        end
      end
    end
    nxt_ready = 1'b1;
    ncmp++;
    if (lg_tid.size() !== 4) begin
      nerr++; $display("FAIL bp_beat_count: got %0d want 4", lg_tid.size());
    end
    for (int k = 0; k < lg_tid.size() && k < 4; k++) begin
      ncmp++;
      if (lg_cyc[k] !== 2 * k + 1 || lg_data[k] !== data_of(0, 0, k) || lg_last[k] !== (k == 3)) begin
        nerr++;
        $display("FAIL bp_beat%0d: cyc=%0d data=%h last=%b, want cyc=%0d data=%h last=%b",
                 k, lg_cyc[k], lg_data[k], lg_last[k], 2 * k + 1, data_of(0, 0, k), k == 3);
      end
    end
  endtask

  task automatic test_enable();
    int stray;
    stray = 0;
    do_reset();
    src_pkts[0] = 1; src_len[0] = 3;
    src_pkts[1] = 1; src_len[1] = 3;
    for (int c = 0; c < 16; c++) begin
      nxt_en = !(c >= 2 && c <= 9);
      run_cycle();
      if (c >= 4 && c <= 9 && (m_tvalid || |s_tready)) stray++;
    end
    nxt_en = 1'b1;
    ncmp++;
    if (stray !== 0) begin
      nerr++; $display("FAIL en_blocked: %0d active cycles while disabled, want 0", stray);
    end
    ncmp++;
    if (lg_tid.size() !== 6) begin
      nerr++; $display("FAIL en_beat_count: got %0d want 6", lg_tid.size());
    end
    for (int k = 0; k < lg_tid.size() && k < 6; k++) begin
      int p, b, ecyc;
      p = (k < 3) ? 0 : 1; b = k % 3; ecyc = (k < 3) ? k + 1 : 11 + b;
      ncmp++;
      if (lg_tid[k] !== p || lg_cyc[k] !== ecyc || lg_data[k] !== data_of(p, 0, b)) begin
        nerr++;
        $display("FAIL en_beat%0d: tid=%0d cyc=%0d data=%h, want tid=%0d cyc=%0d data=%h",
                 k, lg_tid[k], lg_cyc[k], lg_data[k], p, ecyc, data_of(p, 0, b));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_pkts[0] = 1; src_len[0] = 1;
    src_pkts[1] = 1; src_len[1] = 3;
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      if (c == 2) begin
        ncmp++;
        if (m_tvalid !== 1'b0) begin
          nerr++; $display("FAIL single_beat_done: tvalid=%b want 0", m_tvalid);
        end
      end
      if (c == 4) begin
        ncmp++;
        if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== data_of(1, 0, 1)) begin
          nerr++;
          $display("FAIL mid_pkt_before_rst: tvalid=%b tid=%0d data=%h, want 1/1/%h",
                   m_tvalid, m_tid, m_tdata, data_of(1, 0, 1));
        end
      end
    end
    // Reset lands between driving edge and sampling edge of beat 2.
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (m_tvalid !== 1'b0 || s_tready !== 3'b000 || m_tid !== 2'd0) begin
      nerr++;
      $display("FAIL rst_immediate: tvalid=%b tready=%b tid=%0d, want 0/000/0",
               m_tvalid, s_tready, m_tid);
    end
    s_tvalid = '0;
    clear_src();
    src_pkts[0] = 1; src_len[0] = 1; src_pkt[0] = 1;
    src_pkts[1] = 1; src_len[1] = 3;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    clear_log();
    for (int c = 0; c < 8; c++) run_cycle();
    ncmp++;
    if (lg_tid.size() !== 4) begin
      nerr++; $display("FAIL rst_beat_count: got %0d want 4", lg_tid.size());
    end
    for (int k = 0; k < lg_tid.size() && k < 4; k++) begin
      int p, pk, b, ecyc;
      p = (k == 0) ? 0 : 1; pk = (k == 0) ? 1 : 0; b = (k == 0) ? 0 : k - 1;
      ecyc = (k == 0) ? 1 : k + 2;
      ncmp++;
      if (lg_tid[k] !== p || lg_cyc[k] !== ecyc || lg_data[k] !== data_of(p, pk, b)) begin
        nerr++;
        $display("FAIL rst_after_beat%0d: tid=%0d cyc=%0d data=%h, want tid=%0d cyc=%0d data=%h",
                 k, lg_tid[k], lg_cyc[k], lg_data[k], p, ecyc, data_of(p, pk, b));
      end
    end
  endtask

  task automatic test_counter();
    do_reset();
`ifdef ARB_PKT_COUNTER_EN
    src_pkts[2] = 6; src_len[2] = 1;
    for (int c = 0; c < 14; c++) begin
      nxt_rstcnt = (c == 11);
      run_cycle();
      if (c == 3) begin
        ncmp++;
        if (pkt_cnt[64 +: 32] !== 32'd1) begin
          nerr++; $display("FAIL cnt_after_1: got %0d want 1", pkt_cnt[64 +: 32]);
        end
      end
      if (c == 10) begin
        ncmp++;
        if (pkt_cnt[0 +: 64] !== 64'd0) begin
          nerr++; $display("FAIL cnt_other_ports: got %h want 0", pkt_cnt[0 +: 64]);
        end
      end
      if (c == 11) begin
        ncmp++;
        if (pkt_cnt[64 +: 32] !== 32'd5 || m_tvalid !== 1'b1 || m_tlast !== 1'b1) begin
          nerr++;
          $display("FAIL cnt_at_5: cnt=%0d tvalid=%b tlast=%b, want 5/1/1",
                   pkt_cnt[64 +: 32], m_tvalid, m_tlast);
        end
      end
      if (c == 12 || c == 13) begin
        ncmp++;
        if (pkt_cnt[64 +: 32] !== 32'd0) begin
          nerr++; $display("FAIL cnt_cleared c%0d: got %0d want 0", c, pkt_cnt[64 +: 32]);
        end
      end
    end
`else
    src_pkts[0] = 2; src_len[0] = 1;
    for (int c = 0; c < 6; c++) begin
      nxt_rstcnt = (c == 2);
      run_cycle();
    end
    ncmp++;
    if (pkt_cnt !== '0 || lg_tid.size() !== 2) begin
      nerr++;
      $display("FAIL cnt_tied_zero: cnt=%h beats=%0d, want 0 and 2", pkt_cnt, lg_tid.size());
    end
`endif
    nxt_rstcnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nxt_ready = 1'b1; nxt_en = 1'b1; nxt_rstcnt = 1'b0; cyc = 0;
    test_reset();
    test_rr_order();
    test_fairness();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
